// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file: default sizes and
// the bulk-clear state encoding.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer: walks every entry once, one per cycle, then pulses done.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          done,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state;
    logic [AW-1:0] cnt;

    // State and sweep counter; requests outside IDLE are dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == SWEEP);
    assign done       = (state == DONE);
    assign sweep_we   = busy;
    assign sweep_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Two-write, two-read register file with optional write forwarding, optional
// hardwired-zero entry 0, and a sequenced bulk clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    logic [XLEN-1:0] mem [DEPTH];
    logic            sweep_we;
    logic [AW-1:0]   sweep_addr;
    logic            ue0;
    logic            ue1;

    reg_file_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .busy       (clr_busy),
        .done       (clr_done),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Effective write enables: user writes are locked out during the sweep,
    // and writes to entry 0 vanish when it is hardwired to zero.
    always_comb begin
        ue0 = we0 && !sweep_we && !((ZERO_REG != 0) && (wa0 == '0));
        ue1 = we1 && !sweep_we && !((ZERO_REG != 0) && (wa1 == '0));
    end

    // Storage; port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else begin
            if (ue0) mem[wa0] <= wd0;
            if (ue1) mem[wa1] <= wd1;
        end
    end

    // Read muxes: stored value, optionally overridden by this cycle's write.
    always_comb begin
        rd1 = mem[ra1];
        rd2 = mem[ra2];
        if (BYPASS != 0) begin
            if (ue0 && (wa0 == ra1)) rd1 = wd0;
            if (ue1 && (wa1 == ra1)) rd1 = wd1;
            if (ue0 && (wa0 == ra2)) rd2 = wd0;
            if (ue1 && (wa1 == ra2)) rd2 = wd1;
        end
        if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build (forwarding, 32 entries)
// and a no-forwarding 16-entry build.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_cmp = 0;
    int          n_bad = 0;

    // default instance (XLEN 32, DEPTH 32, BYPASS 1)
    logic        we0, we1, clr_req;
    logic [4:0]  wa0, wa1, ra1, ra2;
    logic [31:0] wd0, wd1, rd1, rd2;
    logic        clr_busy, clr_done;

    // no-forwarding instance (DEPTH 16, BYPASS 0)
    logic        bwe0, bwe1, bclr_req;
    logic [3:0]  bwa0, bwa1, bra1, bra2;
    logic [31:0] bwd0, bwd1, brd1, brd2;
    logic        bclr_busy, bclr_done;

    int busy_cnt, done_cnt, done_at, nz;

    always #5 clk = ~clk;

    reg_file_param dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    reg_file_param #(.XLEN(32), .DEPTH(16), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .we0(bwe0), .wa0(bwa0), .wd0(bwd0),
        .we1(bwe1), .wa1(bwa1), .wd1(bwd1),
        .ra1(bra1), .ra2(bra2), .rd1(brd1), .rd2(brd2),
        .clr_req(bclr_req), .clr_busy(bclr_busy), .clr_done(bclr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs are changed on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra1 = 0; ra2 = 0; clr_req = 0;
        bwe0 = 0; bwe1 = 0; bwa0 = 0; bwa1 = 0; bwd0 = 0; bwd1 = 0; bra1 = 0; bra2 = 0; bclr_req = 0;

        // reset state
        ra1 = 5'd5; ra2 = 5'd31;
        #3;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_busy", {31'h0, clr_busy}, 32'h0);
        chk("rst_done", {31'h0, clr_done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // write x5 via port 0, forwarded same cycle, stored next cycle
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
        #1 chk("byp_x5", rd1, 32'hDEADBEEF);
        tick(); we0 = 0;
        #1 chk("st_x5", rd1, 32'hDEADBEEF);

        // both ports to the same address: port 1 wins
        we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222; ra2 = 5'd7;
        #1 chk("byp_collide", rd2, 32'h22222222);
        tick(); we0 = 0; we1 = 0;
        #1 chk("st_collide", rd2, 32'h22222222);

        // distinct addresses both commit
        we0 = 1; wa0 = 5'd3; wd0 = 32'hA0A0A0A0;
        we1 = 1; wa1 = 5'd4; wd1 = 32'hB1B1B1B1;
        tick(); we0 = 0; we1 = 0; ra1 = 5'd3; ra2 = 5'd4;
        #1 chk("dual_p0", rd1, 32'hA0A0A0A0);
        chk("dual_p1", rd2, 32'hB1B1B1B1);

        // entry 0 is hardwired to zero, forwarding included
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = 5'd0;
        #1 chk("zero_byp", rd1, 32'h0);
        tick(); we0 = 0; we1 = 0;
        #1 chk("zero_st", rd1, 32'h0);

        // no-forwarding build: old value this cycle, new value next
        bwe0 = 1; bwa0 = 4'd6; bwd0 = 32'h00001234; bra1 = 4'd6;
        #1 chk("b_nobyp_old", brd1, 32'h0);
        tick(); bwe0 = 0;
        #1 chk("b_st_new", brd1, 32'h00001234);
        bwe1 = 1; bwa1 = 4'd6; bwd1 = 32'h00005678;
        #1 chk("b_nobyp_old2", brd1, 32'h00001234);
        tick(); bwe1 = 0;
        #1 chk("b_st_new2", brd1, 32'h00005678);

        // fill every entry with a nonzero pattern
        for (int i = 1; i < 32; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'h10000000 | 32'(i);
            tick();
        end
        we0 = 0; ra1 = 5'd31; ra2 = 5'd1;
        #1 chk("fill_31", rd1, 32'h1000001F);
        chk("fill_1", rd2, 32'h10000001);

        // request clear together with a user write that must still commit
        we0 = 1; wa0 = 5'd9; wd0 = 32'h00000099; clr_req = 1;
        tick(); clr_req = 0;
        we0 = 1; wa0 = 5'd20; wd0 = 32'h00000055; ra1 = 5'd9; ra2 = 5'd20;
        #1 chk("sw_busy0", {31'h0, clr_busy}, 32'h1);
        chk("sw_req_wr", rd1, 32'h00000099);
        chk("sw_nobyp", rd2, 32'h10000014);

        // sweep: count busy and done, keep hammering writes, retrigger clr_req
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            busy_cnt += int'(clr_busy);
            if (clr_done) begin
                done_cnt++;
                done_at = i;
            end
            we0 = (i < 32); wa0 = 5'd2;  wd0 = 32'h00000055;
            we1 = (i < 32); wa1 = 5'd25; wd1 = 32'h00000BAD;
            clr_req = (i == 5);
            tick();
        end
        we0 = 0; we1 = 0; clr_req = 0;
        chk("sw_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("sw_done_pulses", 32'(done_cnt), 32'd1);
        chk("sw_done_at", 32'(done_at), 32'd32);
        chk("sw_idle_busy", {31'h0, clr_busy}, 32'h0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1 if (rd1 != 32'h0) nz++;
        end
        chk("sw_all_zero", 32'(nz), 32'd0);

        // reset in the middle of a sweep
        we0 = 1; wa0 = 5'd12; wd0 = 32'h0000C0C0;
        we1 = 1; wa1 = 5'd15; wd1 = 32'h0000F0F0;
        tick(); we0 = 0; we1 = 0;
        clr_req = 1;
        tick(); clr_req = 0;
        repeat (10) tick();
        ra1 = 5'd12; ra2 = 5'd15;
        #1 chk("pre_rst_x12", rd1, 32'h0000C0C0);
        rst_n = 0;
        #1 chk("mid_rst_busy", {31'h0, clr_busy}, 32'h0);
        chk("mid_rst_done", {31'h0, clr_done}, 32'h0);
        chk("mid_rst_x12", rd1, 32'h0);
        chk("mid_rst_x15", rd2, 32'h0);
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            done_cnt += int'(clr_done);
        end
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            done_cnt += int'(clr_done);
            busy_cnt += int'(clr_busy);
            tick();
        end
        chk("rst_abort_done", 32'(done_cnt), 32'd0);
        chk("rst_abort_busy", 32'(busy_cnt), 32'd0);
        we1 = 1; wa1 = 5'd12; wd1 = 32'h0000CAFE;
        tick(); we1 = 0;
        #1 chk("post_rst_wr", rd1, 32'h0000CAFE);

        // no-forwarding build sweep covers exactly 16 entries
        bwe0 = 1; bwa0 = 4'd3; bwd0 = 32'h00000033;
        tick(); bwe0 = 0; bra2 = 4'd3;
        #1 chk("b_pre_clr", brd2, 32'h00000033);
        bclr_req = 1;
        tick(); bclr_req = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            busy_cnt += int'(bclr_busy);
            done_cnt += int'(bclr_done);
            tick();
        end
        chk("b_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("b_done_pulses", 32'(done_cnt), 32'd1);
        #1 chk("b_post_clr", brd2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of entries (power of two, >= 4).
REQ-003 SHALL provide parameter AW, default $clog2(DEPTH), address width.
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL provide parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 we0 / wa0 / wd0  input  1 / AW / XLEN  write port 0 enable, address, data.
REQ-009 we1 / wa1 / wd1  input  1 / AW / XLEN  write port 1 enable, address, data.
REQ-010 ra1, ra2  input  AW  read addresses.
REQ-011 rd1, rd2  output  XLEN  combinational read data.
REQ-012 clr_req  input  1  request bulk clear of all entries.
REQ-013 clr_busy  output  1  high while clear sweep is in progress.
REQ-014 clr_done  output  1  one-cycle pulse at sweep completion.

Function
REQ-015 Writes SHALL commit on the rising edge where the port's enable is high; visible in storage the following cycle.
REQ-016 Both ports enabled to the same address SHALL commit wd1 (port 1 priority); distinct addresses SHALL both commit.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, bypass included.
REQ-018 With BYPASS=1, a read whose address matches an enabled write this cycle SHALL return that write data (port 1 over port 0); with BYPASS=0, reads SHALL return stored contents only.
REQ-019 Reads SHALL be combinational, zero-cycle latency, independent of clr state except REQ-023.
REQ-020 Clear FSM states SHALL be IDLE, SWEEP, DONE.
REQ-021 IDLE->SWEEP on clr_req=1 sampled at a rising edge; sweep counter loaded with 0.
REQ-022 In SWEEP, one entry per cycle SHALL be written to 0, counter increments; after entry DEPTH-1 FSM SHALL go to DONE; sweep occupies exactly DEPTH cycles.
REQ-023 In SWEEP, we0/we1 SHALL be ignored (no commit, no bypass); reads return current stored contents.
REQ-024 DONE SHALL last one cycle with clr_done=1, then IDLE unconditionally; clr_req in SWEEP or DONE SHALL be ignored (no queuing).
REQ-025 clr_busy SHALL be 1 exactly in SWEEP; clr_done exactly in DONE; both registered-state decodes.
REQ-026 User writes in IDLE on the cycle clr_req is sampled SHALL commit normally.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all entries to 0, FSM to IDLE, sweep counter to 0.
REQ-028 During and after reset: rd1/rd2=0 (no writes pending), clr_busy=0, clr_done=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse.
REQ-030 Reset deassertion SHALL be assumed synchronised externally; first commit possible on first rising edge after release.

Structure
REQ-031 Package reg_file_pkg SHALL hold the clear-FSM state enum (IDLE, SWEEP, DONE) and default XLEN/DEPTH constants.
REQ-032 Clear FSM and counter SHALL be sub-module reg_file_clr_fsm, exporting busy, done, sweep address, sweep write-enable.
REQ-033 Storage, write arbitration and bypass muxing SHALL live in reg_file_param.

Verification
REQ-034 Write x5=0xDEADBEEF via port 0, next cycle ra1=5 -> rd1=0xDEADBEEF; BYPASS=1 same-cycle read -> 0xDEADBEEF that cycle.
REQ-035 we0 and we1 both to addr 7 (0x11111111 / 0x22222222) -> next cycle rd2=0x22222222; same-cycle bypass also 0x22222222.
REQ-036 Write 0xFFFFFFFF to addr 0 on either port, ra1=0 -> rd1=0 same cycle and after.
REQ-037 Fill all entries nonzero, pulse clr_req -> clr_busy high DEPTH cycles, clr_done one pulse, then all reads 0; writes issued during busy not stored.
REQ-038 Assert rst_n=0 at sweep cycle 10 -> all entries 0 immediately, clr_busy=0, no clr_done; after release, writes work normally.
REQ-039 BYPASS=0, DEPTH=16 build: same-cycle read of written address returns old value (0 after reset), new value next cycle.
